// File: rtl/tdm_demux8_pkg.sv
// Shared definitions for the 8-channel TDM receive path (tdm_demux8).
// State encodings match the transmit side: IDLE=0, RUN=1, PAR=2.
// Optional feature macro: TDM_PARITY_EN (adds a trailing even-parity slot).
package tdm_demux8_pkg;

    // Default channel count and slot index width.
    localparam int TDM_N     = 8;
    localparam int TDM_SEL_W = $clog2(TDM_N);

    // Receiver alignment states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // unaligned, waiting for frame_start
        ST_RUN  = 2'd1,  // collecting data slots 0..N-1
        ST_PAR  = 2'd2   // collecting the parity slot (parity build only)
    } tdm_state_e;

    // Even parity over data plus parity bit: the total count of ones must be even.
    function automatic logic even_parity_ok(input logic par_bit, input logic [TDM_N-1:0] data);
        return ((^data) ^ par_bit) == 1'b0;
    endfunction

endpackage

// File: rtl/tdm_demux8_demux1to8.sv
// demux1to8: combinational 1-to-N one-hot decoder.
// Routes a single input bit to out[sel]; every other output is 0.
// Used by tdm_demux8 to turn the slot index plus the strobe into
// per-bit shadow write enables.
module demux1to8 #(
    parameter int N = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             in,
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]     out
);

    // One-hot decode; N is a power of two so every sel value is in range.
    always_comb begin
        out      = '0;
        out[sel] = in;
    end

endmodule

// File: rtl/tdm_demux8.sv
// tdm_demux8: receive end of the 8-channel time-division link.
// Samples one serial bit per enabled clock, routes slot k to bit k of a
// shadow frame register, and publishes each completed frame on 'out'.
// Optional feature macro: TDM_PARITY_EN -- frames carry one extra
// even-parity slot after slot N-1; a frame is published only when the
// parity checks, otherwise parity_err pulses and out is held.
//
// Output signalling: there is no backpressure. 'valid' is a one-cycle
// pulse meaning 'out' was updated on the previous edge; the consumer must
// take the frame in that cycle (out stays stable until the next pulse).
// sync_err and parity_err are likewise one-cycle pulses. 'en' is a slot
// strobe: edges with en=0 are a full stall and only clear the pulses.
module tdm_demux8
    import tdm_demux8_pkg::*;
#(
    parameter int N = TDM_N,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             frame_start,
    output logic [N-1:0]     out,
    output logic             valid,
    output logic [SEL_W-1:0] slot,
    output logic             sync_err,
    output logic             parity_err,
    output logic [1:0]       dbg_state
);

    localparam logic [SEL_W-1:0] SLOT_FIRST = '0;
    localparam logic [SEL_W-1:0] SLOT_ONE   = SEL_W'(1);
    localparam logic [SEL_W-1:0] SLOT_LAST  = SEL_W'(N - 1);

    tdm_state_e       state;
    logic [N-1:0]     shadow;
    logic [N-1:0]     wen;
    logic             dec_in;
    logic [SEL_W-1:0] dec_sel;

    assign dbg_state = state;

    // A shadow bit is written when a frame_start restarts at slot 0, or
    // when RUN samples a data slot other than 0. Discarded bits (unaligned
    // IDLE, missing frame_start at slot 0, the parity slot) write nothing.
    always_comb begin
        dec_in  = en & (frame_start | ((state == ST_RUN) && (slot != SLOT_FIRST)));
        dec_sel = frame_start ? SLOT_FIRST : slot;
    end

    demux1to8 #(.N(N)) u_dec (
        .in  (dec_in),
        .sel (dec_sel),
        .out (wen)
    );

    // Shadow register: exactly one bit captured per qualifying edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wen[i]) shadow[i] <= din;
            end
        end
    end

    // Alignment FSM, slot counter and output frame register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            slot     <= SLOT_FIRST;
            out      <= '0;
            valid    <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            valid    <= 1'b0;
            sync_err <= 1'b0;
            if (en) begin
                case (state)
                    ST_IDLE: begin
                        // Unaligned bits are dropped silently until a marker.
                        if (frame_start) begin
                            slot  <= SLOT_ONE;
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (frame_start) begin
                            // Marker at slot 0 is the normal frame start;
                            // anywhere else the partial frame is abandoned.
                            if (slot != SLOT_FIRST) sync_err <= 1'b1;
                            slot <= SLOT_ONE;
                        end else if (slot == SLOT_FIRST) begin
                            // Marker expected here but missing: lose lock.
                            sync_err <= 1'b1;
                            state    <= ST_IDLE;
                        end else if (slot == SLOT_LAST) begin
                            slot <= SLOT_FIRST;
`ifdef TDM_PARITY_EN
                            state <= ST_PAR;
`else
                            out   <= {din, shadow[N-2:0]};
                            valid <= 1'b1;
`endif
                        end else begin
                            slot <= slot + SLOT_ONE;
                        end
                    end
`ifdef TDM_PARITY_EN
                    ST_PAR: begin
                        state <= ST_RUN;
                        if (frame_start) begin
                            // Marker in the parity slot: drop the frame and
                            // treat this bit as the new slot 0.
                            sync_err <= 1'b1;
                            slot     <= SLOT_ONE;
                        end else begin
                            slot <= SLOT_FIRST;
                            if (even_parity_ok(din, shadow)) begin
                                out   <= shadow;
                                valid <= 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        state <= ST_IDLE;
                        slot  <= SLOT_FIRST;
                    end
                endcase
            end
        end
    end

`ifdef TDM_PARITY_EN
    // Parity failure pulse, raised by the parity slot of an aligned frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= en && (state == ST_PAR) && !frame_start
                          && !even_parity_ok(din, shadow);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
